altbus_ctrl: RTL and testbench

ALTBUS_CTRL -- requirements
Module: altbus_ctrl

---
 rtl/altbus_pkg.sv | 28 ++
 rtl/altbus_sync.sv | 25 ++
 rtl/altbus_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_altbus_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/altbus_pkg.sv
// Shared definitions for the alternate-bus controller: FSM states,
// register-page codes and the fast-memory decode window tables.
package altbus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WAIT,
    ACK,
    PASS,
    FAULT
  } state_t;

  // A[23:4] value selecting the control register page
  localparam logic [19:0] REG_PAGE = 20'hFFFE0;

  // Register-page action codes on A[3:1]; codes below NWIN enable a window
  localparam logic [2:0] RP_CLR_FAST = 3'd5;
  localparam logic [2:0] RP_SET_FAST = 3'd6;
  localparam logic [2:0] RP_CLR_WIN  = 3'd7;

  // Window tables, index 0 in the rightmost slot.
  // Window 0: A[23:22]=01, window 1: A[23:22]=10.
  localparam logic [4:0][3:0] WIN_BASE = {4'hE, 4'hC, 4'h2, 4'h8, 4'h4};
  localparam logic [4:0][3:0] WIN_MASK = {4'hF, 4'hF, 4'hE, 4'hC, 4'hC};
  localparam logic [4:0][7:0] WIN_WS   = {8'd0, 8'd4, 8'd3, 8'd1, 8'd2};

endpackage

// File: rtl/altbus_sync.sv
// Two-flop synchroniser for the asynchronous CPU address strobe.
// Both flops preset to 1 (strobe inactive) on reset.
module altbus_sync
  import altbus_pkg::*;
(
  input  logic CLKOSC,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw strobe through two flops; preset high in reset
  always_ff @(posedge CLKOSC) begin
    if (!RST) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/altbus_ctrl.sv
// Alternate-bus controller: decodes CPU strobes into register-page
// accesses, fast-memory windows (SDRAM with wait states) or motherboard
// pass-through, and drives DTACK/SLOW/SDRAM strobe accordingly.
// Optional: define ALTBUS_BERR_TIMEOUT_EN to fault stalled SDRAM accesses
// with BERR after TIMEOUT cycles.
module altbus_ctrl
  import altbus_pkg::*;
#(
  parameter int NWIN    = 2,
  parameter int WS_W    = 3,
  parameter int TIMEOUT = 64
) (
  input  logic            CLKOSC,
  input  logic            RST,
  input  logic            AS_INT,
  input  logic            RW,
  input  logic [23:1]     A,
  input  logic            SDRAM_VALID,
  output logic            SDRAM_AS,
  output logic            DTACK_INT,
  output logic            BERR_OUT,
  output logic            SLOW,
  output logic [NWIN-1:0] WIN_EN
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  state_t           state, state_n;
  logic             as_s;
  logic             hit, hit_q;
  logic [2:0]       hit_idx, hit_idx_q;
  logic             is_reg_q;
  logic [2:0]       code_q;
  logic             rw_unused_q;
  logic [NWIN-1:0]  win_en_q, win_en_n;
  logic             fast_q, fast_n;
  logic             slow_q;
  logic             seen_q;
  logic             ack_sd_q;
  logic [WS_W-1:0]  ws_cnt;
  logic [WS_W-1:0]  ws_sel;

  altbus_sync u_sync (
    .CLKOSC (CLKOSC),
    .RST    (RST),
    .d      (AS_INT),
    .q      (as_s)
  );

  // Window hit for the current address; lowest enabled index wins
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned k = 0; k < NWIN; k++) begin
      if (!hit && win_en_q[k] && ((A[23:20] & WIN_MASK[k]) == WIN_BASE[k])) begin
        hit     = 1'b1;
        hit_idx = 3'(k);
      end
    end
  end

  assign ws_sel = WS_W'(WIN_WS[hit_idx_q]);

`ifdef ALTBUS_BERR_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  // Stall counter: cleared on the way into WAIT, runs while SDRAM is not ready
  always_ff @(posedge CLKOSC) begin
    if (!RST) begin
      to_cnt <= '0;
    end else if (state == DECODE) begin
      to_cnt <= '0;
    end else if (state == WAIT && !seen_q && SDRAM_VALID) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  logic [TO_W-1:0] timeout_unused;
  assign timeout_unused = TO_W'(TIMEOUT);
`endif

  // Next-state decode
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (!as_s) state_n = DECODE;
      DECODE: begin
        if (as_s)          state_n = IDLE;
        else if (is_reg_q) state_n = ACK;
        else if (hit_q)    state_n = WAIT;
        else               state_n = PASS;
      end
      WAIT: begin
        if (as_s) begin
          state_n = IDLE;
        end else if (seen_q) begin
          if (ws_cnt == WS_W'(1)) state_n = ACK;
        end else if (!SDRAM_VALID) begin
          if (ws_sel == '0) state_n = ACK;
        end
`ifdef ALTBUS_BERR_TIMEOUT_EN
        else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          state_n = FAULT;
        end
`endif
      end
      ACK:    if (as_s) state_n = IDLE;
      PASS:   if (as_s) state_n = IDLE;
      FAULT:  if (as_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Register-page side effects, applied only in the DECODE cycle
  always_comb begin
    win_en_n = win_en_q;
    fast_n   = fast_q;
    if (state == DECODE && is_reg_q) begin
      for (int unsigned k = 0; k < NWIN; k++) begin
        if (code_q == 3'(k)) win_en_n[k] = 1'b1;
      end
      case (code_q)
        RP_CLR_FAST: fast_n   = 1'b0;
        RP_SET_FAST: fast_n   = 1'b1;
        RP_CLR_WIN:  win_en_n = '0;
        default: ;
      endcase
    end
  end

  // State register, control registers and registered SLOW
  always_ff @(posedge CLKOSC) begin
    if (!RST) begin
      state    <= IDLE;
      win_en_q <= '1;
      fast_q   <= 1'b1;
      slow_q   <= 1'b0;
    end else begin
      state    <= state_n;
      win_en_q <= win_en_n;
      fast_q   <= fast_n;
      slow_q   <= ~fast_n | (state_n == PASS);
    end
  end

  // Capture the access attributes when a strobe is accepted in IDLE
  always_ff @(posedge CLKOSC) begin
    if (!RST) begin
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      is_reg_q    <= 1'b0;
      code_q      <= '0;
      rw_unused_q <= 1'b1;
    end else if (state == IDLE && !as_s) begin
      hit_q       <= hit;
      hit_idx_q   <= hit_idx;
      is_reg_q    <= (A[23:4] == REG_PAGE);
      code_q      <= A[3:1];
      rw_unused_q <= RW;
    end
  end

  // Wait-state counting: after the first ready cycle, load the window's
  // count and step down; ACK is taken when it reaches 1
  always_ff @(posedge CLKOSC) begin
    if (!RST) begin
      seen_q   <= 1'b0;
      ws_cnt   <= '0;
      ack_sd_q <= 1'b0;
    end else begin
      case (state)
        DECODE: begin
          seen_q   <= 1'b0;
          ws_cnt   <= '0;
          ack_sd_q <= 1'b0;
        end
        WAIT: begin
          ack_sd_q <= 1'b1;
          if (seen_q) begin
            ws_cnt <= ws_cnt - WS_W'(1);
          end else if (!SDRAM_VALID) begin
            seen_q <= 1'b1;
            ws_cnt <= ws_sel;
          end
        end
        default: ;
      endcase
    end
  end

  assign SDRAM_AS  = ~((state == WAIT) | ((state == ACK) & ack_sd_q));
  assign DTACK_INT = ~(state == ACK);
  assign SLOW      = slow_q;
  assign WIN_EN    = win_en_q;
`ifdef ALTBUS_BERR_TIMEOUT_EN
  assign BERR_OUT  = ~(state == FAULT);
`else
  assign BERR_OUT  = 1'b1;
`endif

endmodule

// File: tb/tb_altbus_ctrl.sv
// Directed bench for altbus_ctrl: expected values are queued when the
// stimulus is applied and popped as each output is sampled on the
// falling clock edge.
module tb_altbus_ctrl;

  logic        CLKOSC;
  logic        RST;
  logic        AS_INT;
  logic        RW;
  logic [23:1] A;
  logic        SDRAM_VALID;
  logic        SDRAM_AS;
  logic        DTACK_INT;
  logic        BERR_OUT;
  logic        SLOW;
  logic [1:0]  WIN_EN;

  int n_assert;
  int n_fail;
  logic [7:0] exp_q[$];

  altbus_ctrl #(.NWIN(2), .WS_W(3), .TIMEOUT(64)) dut (
    .CLKOSC      (CLKOSC),
    .RST         (RST),
    .AS_INT      (AS_INT),
    .RW          (RW),
    .A           (A),
    .SDRAM_VALID (SDRAM_VALID),
    .SDRAM_AS    (SDRAM_AS),
    .DTACK_INT   (DTACK_INT),
    .BERR_OUT    (BERR_OUT),
    .SLOW        (SLOW),
    .WIN_EN      (WIN_EN)
  );

  initial CLKOSC = 1'b0;
  always #5 CLKOSC = ~CLKOSC;

  task automatic step(input int n);
    repeat (n) @(negedge CLKOSC);
  endtask

  task automatic push(input logic [7:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [7:0] obs);
    logic [7:0] exp;
    n_assert++;
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    else exp = 8'hEE;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [23:0] addr);
    A      = addr[23:1];
    RW     = 1'b1;
    AS_INT = 1'b0;
  endtask

  initial begin
    logic berr_seen;
    logic dtack_seen;
    n_assert    = 0;
    n_fail      = 0;
    RST         = 1'b0;
    AS_INT      = 1'b1;
    RW          = 1'b1;
    A           = '0;
    SDRAM_VALID = 1'b1;
    berr_seen   = 1'b0;
    dtack_seen  = 1'b0;

    // Reset state
    step(3);
    push(8'd1); push(8'd1); push(8'd1); push(8'd0); push(8'd3);
    check("rst_dtack", 8'(DTACK_INT));
    check("rst_berr",  8'(BERR_OUT));
    check("rst_sdas",  8'(SDRAM_AS));
    check("rst_slow",  8'(SLOW));
    check("rst_winen", 8'(WIN_EN));
    RST = 1'b1;
    step(2);

    // Window 0 read, 2 wait states, SDRAM ready 4 cycles after SDRAM_AS
    strobe(24'h400000);
    push(8'd1); push(8'd0); push(8'd0);
    step(3); check("w0_sdas_pre", 8'(SDRAM_AS));
    step(1); check("w0_sdas_wait", 8'(SDRAM_AS));
    check("w0_slow", 8'(SLOW));
    step(4); SDRAM_VALID = 1'b0;
    push(8'd1); push(8'd1); push(8'd0); push(8'd0);
    step(1); check("w0_dtack_v1", 8'(DTACK_INT));
    step(1); check("w0_dtack_v2", 8'(DTACK_INT));
    step(1); check("w0_dtack_v3", 8'(DTACK_INT));
    check("w0_sdas_ack", 8'(SDRAM_AS));
    AS_INT = 1'b1; SDRAM_VALID = 1'b1;
    push(8'd0); push(8'd0); push(8'd1); push(8'd1);
    step(1); check("w0_dtack_hold1", 8'(DTACK_INT));
    step(1); check("w0_dtack_hold2", 8'(DTACK_INT));
    step(1); check("w0_dtack_rel", 8'(DTACK_INT));
    check("w0_sdas_rel", 8'(SDRAM_AS));
    step(2);

    // Window 1, one wait state
    strobe(24'h800000);
    push(8'd0);
    step(4); check("w1_sdas_wait", 8'(SDRAM_AS));
    step(1); SDRAM_VALID = 1'b0;
    push(8'd1); push(8'd0);
    step(1); check("w1_dtack_v1", 8'(DTACK_INT));
    step(1); check("w1_dtack_v2", 8'(DTACK_INT));
    AS_INT = 1'b1; SDRAM_VALID = 1'b1;
    push(8'd1);
    step(4); check("w1_dtack_rel", 8'(DTACK_INT));
    step(2);

    // Register page code 7: disable all windows
    strobe(24'hFFFE0E);
    push(8'd0); push(8'd0); push(8'd1);
    step(4); check("rp7_winen", 8'(WIN_EN));
    check("rp7_dtack", 8'(DTACK_INT));
    check("rp7_sdas", 8'(SDRAM_AS));
    AS_INT = 1'b1;
    push(8'd0); push(8'd1);
    step(2); check("rp7_dtack_hold", 8'(DTACK_INT));
    step(1); check("rp7_dtack_rel", 8'(DTACK_INT));
    step(2);

    // Former window address now passes to the motherboard
    strobe(24'h400000);
    push(8'd0); push(8'd1); push(8'd1); push(8'd1); push(8'd1);
    step(3); check("pass_slow_pre", 8'(SLOW));
    step(1); check("pass_slow", 8'(SLOW));
    check("pass_sdas", 8'(SDRAM_AS));
    check("pass_dtack", 8'(DTACK_INT));
    step(1); check("pass_sdas_hold", 8'(SDRAM_AS));
    AS_INT = 1'b1;
    push(8'd1); push(8'd0);
    step(2); check("pass_slow_end", 8'(SLOW));
    step(1); check("pass_slow_idle", 8'(SLOW));
    step(2);

    // Register page code 0: enable window 0
    strobe(24'hFFFE00);
    push(8'd1); push(8'd0);
    step(4); check("rp0_winen", 8'(WIN_EN));
    check("rp0_dtack", 8'(DTACK_INT));
    AS_INT = 1'b1;
    step(4);

    // Register page code 4: no action, still acknowledged
    strobe(24'hFFFE08);
    push(8'd1); push(8'd0);
    step(4); check("rp4_winen", 8'(WIN_EN));
    check("rp4_dtack", 8'(DTACK_INT));
    AS_INT = 1'b1;
    step(4);

    // Code 5 clears FAST (SLOW high in IDLE), code 6 sets it again
    strobe(24'hFFFE0A);
    push(8'd1);
    step(4); check("rp5_slow_ack", 8'(SLOW));
    AS_INT = 1'b1;
    push(8'd1); push(8'd1);
    step(4); check("rp5_slow_idle", 8'(SLOW));
    check("rp5_dtack_idle", 8'(DTACK_INT));
    strobe(24'hFFFE0C);
    step(4);
    AS_INT = 1'b1;
    push(8'd0);
    step(4); check("rp6_slow_idle", 8'(SLOW));
    step(2);

    // Strobe released during WAIT aborts without DTACK
    strobe(24'h400000);
    push(8'd0);
    step(4); check("ab_sdas_wait", 8'(SDRAM_AS));
    AS_INT = 1'b1;
    push(8'd0); push(8'd1); push(8'd1); push(8'd1); push(8'd1);
    step(2); check("ab_sdas_pre", 8'(SDRAM_AS));
    check("ab_dtack_pre", 8'(DTACK_INT));
    step(1); check("ab_sdas_idle", 8'(SDRAM_AS));
    check("ab_dtack_idle", 8'(DTACK_INT));
    step(2); check("ab_dtack_late", 8'(DTACK_INT));
    step(2);

    // Reset during WAIT
    strobe(24'h400000);
    push(8'd0);
    step(4); check("rw_sdas_wait", 8'(SDRAM_AS));
    RST = 1'b0; AS_INT = 1'b1;
    push(8'd1); push(8'd3); push(8'd1); push(8'd0);
    step(1); check("rw_sdas", 8'(SDRAM_AS));
    check("rw_winen", 8'(WIN_EN));
    check("rw_dtack", 8'(DTACK_INT));
    check("rw_slow", 8'(SLOW));
    RST = 1'b1;
    step(2);

    // SDRAM never ready
    strobe(24'h400000);
    push(8'd0);
    step(4); check("to_sdas_wait", 8'(SDRAM_AS));
`ifdef ALTBUS_BERR_TIMEOUT_EN
    push(8'd1); push(8'd0); push(8'd1); push(8'd1);
    step(63); check("to_berr_pre", 8'(BERR_OUT));
    step(1); check("to_berr", 8'(BERR_OUT));
    check("to_dtack", 8'(DTACK_INT));
    check("to_sdas", 8'(SDRAM_AS));
    AS_INT = 1'b1;
    push(8'd1);
    step(3); check("to_berr_rel", 8'(BERR_OUT));
`else
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (!BERR_OUT)  berr_seen  = 1'b1;
      if (!DTACK_INT) dtack_seen = 1'b1;
    end
    push(8'd0); push(8'd0); push(8'd0);
    check("nto_berr_seen", 8'(berr_seen));
    check("nto_dtack_seen", 8'(dtack_seen));
    check("nto_sdas_wait", 8'(SDRAM_AS));
    AS_INT = 1'b1;
    push(8'd1);
    step(4); check("nto_sdas_idle", 8'(SDRAM_AS));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
